// File: rtl/run_sequencer_if.sv
// Handshake and memory-side bundle between the run sequencer and its harness.
// Latency: none, wiring only.
// Backpressure: carries in_valid/in_ready and out_valid/out_ready pairs unchanged.
interface run_sequencer_if #(
    parameter int AW = 8
);
    // Run control
    logic          go;
    logic          start;
    logic          done;
    logic          busy;
    logic          fin;
    logic          timeout_err;
    logic [9:0]    cycles;

    // Operand stream in
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;

    // Data-memory side port
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    // Result stream out
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready;

    // Sequencer side
    modport master (
        input  go, done, in_valid, in_data, mem_rdata, out_ready,
        output start, busy, fin, timeout_err, cycles, in_ready,
               mem_we, mem_re, mem_addr, mem_wdata, out_valid, out_data
    );

    // Harness side (stimulus, memory, processor)
    modport slave (
        output go, done, in_valid, in_data, mem_rdata, out_ready,
        input  start, busy, fin, timeout_err, cycles, in_ready,
               mem_we, mem_re, mem_addr, mem_wdata, out_valid, out_data
    );
endinterface

// File: rtl/run_sequencer.sv
// Test-run sequencer: loads operands into data memory, launches the core, waits for done, drains results.
// Latency: go->in_ready 1 cycle; last operand->start fall 2 cycles; done->first out_valid 1 cycle.
// Backpressure: LOAD writes only on in_valid&&in_ready; DRAIN holds mem_addr/out_data while out_ready is low.
module run_sequencer #(
    parameter int AW        = 8,
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 8,
    parameter int RES_BASE  = 8,
    parameter int RES_LEN   = 4,
    parameter int TIMEOUT   = 1000
) (
    input  logic           clk,
    input  logic           reset,
    run_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_RUN,
        S_DRAIN,
        S_FINISH
    } state_t;

    // Byte index is wide enough for the address and for any sensible stream length;
    // the address wraps naturally because only the low AW bits feed the adder.
    localparam int IW = (AW > 16) ? AW : 16;

    localparam logic [IW-1:0] LOAD_LAST   = IW'((LOAD_LEN > 0) ? LOAD_LEN - 1 : 0);
    localparam logic [IW-1:0] RES_LAST    = IW'((RES_LEN > 0) ? RES_LEN - 1 : 0);
    localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
    localparam logic [AW-1:0] RES_BASE_A  = AW'(RES_BASE);
    localparam logic [9:0]    TIMEOUT_C   = 10'(TIMEOUT);
    localparam logic [9:0]    CYC_MAX     = 10'h3FF;
    // done is ignored until two RUN cycles have completed
    localparam logic [9:0]    BLANK_CYC   = 10'd2;

    state_t        state;
    logic [IW-1:0] idx;
    logic [9:0]    cycles_q;
    logic          start_q;
    logic          in_ready_q;
    logic          mem_re_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          fin_q;
    logic          terr_q;

    logic          load_hs;
    logic          drain_hs;
    logic [9:0]    cycles_inc;
    logic          done_seen;
    logic          timed_out;

    assign load_hs    = in_ready_q && bus.in_valid;
    assign drain_hs   = out_valid_q && bus.out_ready;
    assign cycles_inc = (cycles_q == CYC_MAX) ? cycles_q : cycles_q + 10'd1;
    // cycles_q holds the number of RUN cycles already completed, so this
    // admits done from the third RUN cycle onward
    assign done_seen  = bus.done && (cycles_q >= BLANK_CYC);
    assign timed_out  = cycles_inc >= TIMEOUT_C;

    // Sequencer state, byte index, run counter and all registered output decodes
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            cycles_q    <= '0;
            start_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_re_q    <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
            terr_q      <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.go) begin
                        terr_q   <= 1'b0;
                        cycles_q <= '0;
                        idx      <= '0;
                        busy_q   <= 1'b1;
                        start_q  <= 1'b1;
                        if (LOAD_LEN == 0) begin
                            state <= S_LAUNCH;
                        end else begin
                            state      <= S_LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (load_hs) begin
                        idx <= idx + 1'b1;
                        if (idx == LOAD_LAST) begin
                            state      <= S_LAUNCH;
                            in_ready_q <= 1'b0;
                        end
                    end
                end

                // Single cycle with start still high; the core sees start fall on entry to RUN
                S_LAUNCH: begin
                    state   <= S_RUN;
                    start_q <= 1'b0;
                end

                S_RUN: begin
                    cycles_q <= cycles_inc;
                    // done takes priority over a timeout landing on the same cycle
                    if (done_seen) begin
                        idx <= '0;
                        if (RES_LEN == 0) begin
                            state <= S_FINISH;
                            fin_q <= 1'b1;
                        end else begin
                            state       <= S_DRAIN;
                            mem_re_q    <= 1'b1;
                            out_valid_q <= 1'b1;
                        end
                    end else if (timed_out) begin
                        terr_q <= 1'b1;
                        state  <= S_FINISH;
                        fin_q  <= 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (drain_hs) begin
                        idx <= idx + 1'b1;
                        if (idx == RES_LAST) begin
                            state       <= S_FINISH;
                            mem_re_q    <= 1'b0;
                            out_valid_q <= 1'b0;
                            fin_q       <= 1'b1;
                        end
                    end
                end

                S_FINISH: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end

                default: begin
                    state       <= S_IDLE;
                    idx         <= '0;
                    start_q     <= 1'b0;
                    in_ready_q  <= 1'b0;
                    mem_re_q    <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // Registered decodes straight to the ports
    assign bus.start       = start_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.mem_re      = mem_re_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = busy_q;
    assign bus.fin         = fin_q;
    assign bus.timeout_err = terr_q;
    assign bus.cycles      = cycles_q;

    // Write strobe and data follow the operand handshake in the same cycle
    assign bus.mem_we    = load_hs;
    assign bus.mem_wdata = load_hs ? bus.in_data : 8'h00;

    // Address is a pure function of state and index, so it stays put under out_ready stalls
    assign bus.mem_addr = (state == S_LOAD)  ? (LOAD_BASE_A + idx[AW-1:0]) :
                          (state == S_DRAIN) ? (RES_BASE_A + idx[AW-1:0])  : '0;

    // Memory read data passes straight through while a result is offered
    assign bus.out_data = out_valid_q ? bus.mem_rdata : 8'h00;

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: scripted run model with per-cycle output comparison plus literal spot checks.
// Latency: model predicts every output cycle by cycle from the run timeline.
// Backpressure: exercises in_valid gaps and out_ready stalls, fixed and random.
module tb_run_sequencer;

    localparam int AW = 8;
    localparam int LB = 0;
    localparam int LL = 8;
    localparam int RB = 8;
    localparam int RL = 4;
    localparam int TO = 1000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    run_sequencer_if #(.AW(AW)) bus ();
    run_sequencer_if #(.AW(8))  bus_b ();
    run_sequencer_if #(.AW(8))  bus_c ();

    run_sequencer #(.AW(AW), .LOAD_BASE(LB), .LOAD_LEN(LL), .RES_BASE(RB), .RES_LEN(RL), .TIMEOUT(TO))
        dut (.clk(clk), .reset(reset), .bus(bus));

    // Wrapping load base, no result bytes, tiny timeout
    run_sequencer #(.AW(8), .LOAD_BASE(254), .LOAD_LEN(4), .RES_BASE(0), .RES_LEN(0), .TIMEOUT(5))
        dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    // Nothing to load, nothing to drain
    run_sequencer #(.AW(8), .LOAD_BASE(0), .LOAD_LEN(0), .RES_BASE(0), .RES_LEN(0), .TIMEOUT(1000))
        dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    int total = 0;
    int bad   = 0;

    // Data memory: operand region written by the DUT, result region filled by the core model
    logic [7:0] lmem [256];
    logic [7:0] rmem [256];
    logic [7:0] wa   [4] = '{8'd254, 8'd255, 8'd0, 8'd1};

    always @(posedge clk) if (bus.mem_we) lmem[bus.mem_addr] <= bus.mem_wdata;
    assign bus.mem_rdata   = rmem[bus.mem_addr];
    assign bus_b.mem_rdata = 8'h00;
    assign bus_c.mem_rdata = 8'h00;

    // Expected outputs and model state carried across runs
    logic       e_start, e_in_ready, e_mem_we, e_mem_re, e_out_valid, e_busy, e_fin, e_terr;
    logic [7:0] e_mem_addr, e_mem_wdata, e_out_data;
    logic [9:0] e_cycles;
    logic       md_terr;
    logic [9:0] md_cycles;
    bit         chk_en = 1'b0;
    int         fin_cnt = 0;
    int         ov_cnt  = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_idle(input logic b);
        e_start = 0; e_in_ready = 0; e_mem_we = 0; e_mem_re = 0; e_out_valid = 0; e_fin = 0;
        e_mem_addr = 0; e_mem_wdata = 0; e_out_data = 0;
        e_busy = b; e_terr = md_terr; e_cycles = md_cycles;
    endtask

    // Single compare process on the main DUT, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("start", bus.start, e_start);
            chk("in_ready", bus.in_ready, e_in_ready);
            chk("mem_we", bus.mem_we, e_mem_we);
            chk("mem_re", bus.mem_re, e_mem_re);
            chk("out_valid", bus.out_valid, e_out_valid);
            chk("busy", bus.busy, e_busy);
            chk("fin", bus.fin, e_fin);
            chk("timeout_err", bus.timeout_err, e_terr);
            chk("cycles", bus.cycles, e_cycles);
            if (e_mem_we) chk("wr_addr_data", {bus.mem_addr, bus.mem_wdata}, {e_mem_addr, e_mem_wdata});
            if (e_mem_re) chk("rd_addr", bus.mem_addr, e_mem_addr);
            if (e_out_valid) chk("out_data", bus.out_data, e_out_data);
        end
    end

    // Event tallies used by the literal checks
    always @(negedge clk) begin
        if (bus.fin) fin_cnt <= fin_cnt + 1;
        if (bus.out_valid) ov_cnt <= ov_cnt + 1;
    end

    // One complete run on the main DUT, expectations written from the run timeline
    task automatic do_run(input int vmode, input int done_at, input bit done_early,
                          input int rmode, input int rst_after, input bit fixed_ops);
        logic [7:0] ops [LL];
        logic [7:0] res [RL];
        int  k, n, j, t, stall;
        bit  v, r, by_done;
        for (int i = 0; i < LL; i++) ops[i] = fixed_ops ? 8'(8'h11 + i) : 8'($urandom);
        for (int i = 0; i < RL; i++) res[i] = 8'($urandom);

        // go cycle, still idle
        exp_idle(0);
        bus.go = 1; bus.in_valid = 0; bus.done = 0; bus.out_ready = 0;
        tick();
        md_terr = 0; md_cycles = 0;

        // operand load
        k = 0; t = 0;
        while (k < LL) begin
            exp_idle(1);
            case (vmode)
                0:       v = 1;
                1:       v = (t % 2 == 0);
                default: v = 1'($urandom);
            endcase
            bus.go = 1'($urandom);
            bus.in_valid = v;
            bus.in_data = v ? ops[k] : 8'($urandom);
            bus.done = done_early;
            e_start = 1; e_in_ready = 1; e_mem_we = v;
            e_mem_addr = 8'(LB + k); e_mem_wdata = bus.in_data;
            tick();
            if (v) k++;
            t++;
        end
        for (int i = 0; i < LL; i++) chk("load_mem", lmem[8'(LB + i)], ops[i]);

        // launch: start still high, stray in_valid must not write
        exp_idle(1); e_start = 1;
        bus.go = 1'($urandom); bus.in_valid = 1'($urandom); bus.in_data = 8'($urandom);
        tick();

        // the core produces its results during the run
        for (int i = 0; i < RL; i++) rmem[8'(RB + i)] = res[i];

        // run until done (after blanking) or timeout
        n = 1; by_done = 0;
        forever begin
            exp_idle(1); e_cycles = 10'(n - 1);
            bus.go = 1'($urandom); bus.in_valid = 1'($urandom);
            bus.done = done_early || (done_at > 0 && n >= done_at);
            by_done = bus.done && (n >= 3);
            tick();
            if (by_done || n >= TO) break;
            n++;
        end
        md_cycles = 10'(n);
        if (!by_done) md_terr = 1;

        // result drain
        if (by_done) begin
            j = 0; stall = 0;
            while (j < RL) begin
                exp_idle(1); e_mem_re = 1; e_out_valid = 1;
                e_mem_addr = 8'(RB + j); e_out_data = res[j];
                bus.go = 1'($urandom); bus.in_valid = 1'($urandom);
                if (rst_after >= 0 && j == rst_after) begin
                    bus.out_ready = 0; bus.go = 0; reset = 1;
                    tick();
                    reset = 0; bus.done = 0;
                    md_terr = 0; md_cycles = 0;
                    exp_idle(0);
                    tick();
                    return;
                end
                case (rmode)
                    0: r = 1;
                    1: begin
                        r = !(j == 2 && stall < 3);
                        if (!r) stall++;
                    end
                    default: r = 1'($urandom);
                endcase
                bus.out_ready = r;
                tick();
                if (r) j++;
            end
        end

        // finish pulse, then back to idle
        exp_idle(1); e_fin = 1;
        bus.go = 1'($urandom); bus.done = 0; bus.out_ready = 0; bus.in_valid = 0;
        tick();
        exp_idle(0); bus.go = 0;
        tick();
    endtask

    // go plus four operand bytes on dut_b; ends at the start of RUN cycle 1
    task automatic b_load();
        bus_b.go = 1;
        tick();
        bus_b.go = 0;
        for (int i = 0; i < 4; i++) begin
            bus_b.in_valid = 1; bus_b.in_data = 8'(8'hA0 + i);
            #1;
            if (i == 0) chk("b_terr_clear", bus_b.timeout_err, 0);
            chk("b_we", bus_b.mem_we, 1);
            chk("b_wrap_addr", bus_b.mem_addr, wa[i]);
            tick();
        end
        #1;
        chk("b_launch_start", bus_b.start, 1);
        chk("b_launch_we", bus_b.mem_we, 0);
        tick();
        bus_b.in_valid = 0;
    endtask

    int fc0, oc0;

    initial begin
        bus.go = 0; bus.in_valid = 0; bus.in_data = 0; bus.done = 0; bus.out_ready = 0;
        bus_b.go = 0; bus_b.in_valid = 0; bus_b.in_data = 0; bus_b.done = 0; bus_b.out_ready = 0;
        bus_c.go = 0; bus_c.in_valid = 0; bus_c.in_data = 0; bus_c.done = 0; bus_c.out_ready = 0;
        for (int i = 0; i < 256; i++) begin
            lmem[i] = 8'h00;
            rmem[i] = 8'($urandom);
        end
        md_terr = 0; md_cycles = 0;
        exp_idle(0);

        // reset state
        reset = 1;
        tick();
        chk_en = 1;
        tick();
        reset = 0;
        tick();

        // nominal run with fixed operands and done after 40 RUN cycles
        fc0 = fin_cnt;
        do_run(0, 40, 0, 0, -1, 1);
        chk("nom_cycles", bus.cycles, 10'd40);
        chk("nom_terr", bus.timeout_err, 0);
        chk("nom_fin_once", 16'(fin_cnt - fc0), 1);
        chk("nom_mem0", lmem[0], 8'h11);
        chk("nom_mem7", lmem[7], 8'h18);

        // backpressure on both streams
        do_run(1, 25, 0, 1, -1, 0);

        // timeout: done never comes
        oc0 = ov_cnt;
        do_run(0, 0, 0, 0, -1, 0);
        chk("to_cycles", bus.cycles, 10'd1000);
        chk("to_terr", bus.timeout_err, 1);
        chk("to_no_out", 16'(ov_cnt - oc0), 0);

        // next run clears the sticky error; done held high from the start is blanked
        do_run(0, 0, 1, 0, -1, 0);
        chk("blank_cycles", bus.cycles, 10'd3);
        chk("blank_terr", bus.timeout_err, 0);

        // reset during drain, then a fresh run
        do_run(2, 12, 0, 0, 1, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cycles", bus.cycles, 0);
        do_run(0, 7, 0, 0, -1, 0);
        chk("fresh_cycles", bus.cycles, 10'd7);

        // randomized runs
        for (int r = 0; r < 6; r++)
            do_run($urandom_range(0, 2), $urandom_range(3, 60), 0, $urandom_range(0, 2), -1, 0);

        // dut_b: done and timeout on the same cycle, done wins
        b_load();
        for (int n = 1; n <= 5; n++) begin
            bus_b.done = (n == 5);
            #1;
            chk("b_run_start", bus_b.start, 0);
            tick();
        end
        chk("b_coll_fin", bus_b.fin, 1);
        chk("b_coll_terr", bus_b.timeout_err, 0);
        chk("b_coll_cycles", bus_b.cycles, 10'd5);
        bus_b.done = 0;
        tick();
        chk("b_idle_busy", bus_b.busy, 0);

        // dut_b: timeout after five RUN cycles
        b_load();
        repeat (5) tick();
        chk("b_to_fin", bus_b.fin, 1);
        chk("b_to_terr", bus_b.timeout_err, 1);
        chk("b_to_cycles", bus_b.cycles, 10'd5);
        tick();

        // dut_b: done high before launch is taken only in RUN cycle 3
        bus_b.done = 1;
        b_load();
        tick();
        tick();
        chk("b_blank_fin", bus_b.fin, 0);
        chk("b_blank_busy", bus_b.busy, 1);
        tick();
        chk("b_blank_fin3", bus_b.fin, 1);
        chk("b_blank_cycles", bus_b.cycles, 10'd3);
        bus_b.done = 0;
        tick();

        // dut_c: zero lengths go IDLE -> LAUNCH -> RUN -> FINISH
        bus_c.go = 1;
        tick();
        bus_c.go = 0; bus_c.in_valid = 1;
        #1;
        chk("c_launch_start", bus_c.start, 1);
        chk("c_launch_rdy", bus_c.in_ready, 0);
        chk("c_launch_we", bus_c.mem_we, 0);
        chk("c_launch_busy", bus_c.busy, 1);
        tick();
        bus_c.in_valid = 0; bus_c.done = 1;
        chk("c_run_start", bus_c.start, 0);
        repeat (3) tick();
        chk("c_fin", bus_c.fin, 1);
        chk("c_cycles", bus_c.cycles, 10'd3);
        chk("c_no_out", bus_c.out_valid, 0);
        bus_c.done = 0;
        tick();
        chk("c_idle_busy", bus_c.busy, 0);

        tick();
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
